// File: rtl/riscv_imem_prefetch_pkg.sv
// riscv_imem_prefetch_pkg
//   Shared constants and helpers for the instruction-memory prefetch buffer.
//   Holds no types; the buffer entry layout stays local to the buffer itself.
//   Contents:
//     PARCEL_ALIGN_MASK : low address bits that must be zero for a fetch
//     is_aligned()      : true when a fetch address is parcel-aligned
package riscv_imem_prefetch_pkg;

  localparam logic [1:0] PARCEL_ALIGN_MASK = 2'b11;

  function automatic logic is_aligned(input logic [1:0] adr_lsb);
    return (adr_lsb & PARCEL_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/riscv_imem_prefetch.sv
// riscv_imem_prefetch
//   In-order instruction prefetch buffer between the fetch stage and an
//   instruction memory with a req/gnt request phase and an in-order ack phase.
//   Ports:
//     clk, rstn                 : clock, asynchronous active-low reset
//     if_nxt_pc                 : fetch address offered by the core
//     if_stall_nxt_pc           : address not accepted this cycle
//     if_stall                  : core not consuming the head parcel
//     if_flush                  : drop all fetched and outstanding parcels
//     if_parcel/_pc/_valid      : head parcel data, address and valid
//     if_parcel_misaligned      : head address was not parcel-aligned
//     if_parcel_page_fault      : head response came back with an error
//     imem_req/imem_adr         : memory request and address
//     imem_gnt                  : request accepted this cycle
//     imem_ack/imem_q/imem_err  : in-order response, data and error
module riscv_imem_prefetch
  import riscv_imem_prefetch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [XLEN-1:0]        if_nxt_pc,
  output logic                   if_stall_nxt_pc,
  input  logic                   if_stall,
  input  logic                   if_flush,
  output logic [PARCEL_SIZE-1:0] if_parcel,
  output logic [XLEN-1:0]        if_parcel_pc,
  output logic                   if_parcel_valid,
  output logic                   if_parcel_misaligned,
  output logic                   if_parcel_page_fault,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_adr,
  input  logic                   imem_gnt,
  input  logic                   imem_ack,
  input  logic [PARCEL_SIZE-1:0] imem_q,
  input  logic                   imem_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]        pc;
    logic [PARCEL_SIZE-1:0] parcel;
    logic                   filled;
    logic                   misaligned;
    logic                   page_fault;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_alloc_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_aligned;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  entry_t           w_head;
  logic [CNT_W-1:0] w_unfilled_cnt;
  logic             w_fill_hit;
  logic [PTR_W-1:0] w_fill_idx;
  logic             w_flush_dec;

  // Stale acks still in flight occupy slots too, so a flush cannot be used
  // to overrun the memory's response queue.
  assign w_aligned = is_aligned(if_nxt_pc[1:0]);
  assign w_full    = (r_alloc_cnt + r_drop_cnt) == CNT_W'(DEPTH);

  assign if_stall_nxt_pc = !rstn | w_full | if_flush | (w_aligned & !imem_gnt);
  assign imem_req        = rstn & !w_full & !if_flush & w_aligned;
  assign imem_adr        = if_nxt_pc;
  assign w_push          = !if_stall_nxt_pc;

  assign w_head               = r_mem[r_rptr];
  assign if_parcel            = w_head.parcel;
  assign if_parcel_pc         = w_head.pc;
  assign if_parcel_misaligned = w_head.misaligned;
  assign if_parcel_page_fault = w_head.page_fault;
  assign if_parcel_valid      = w_head.filled & !if_flush;
  assign w_pop                = if_parcel_valid & !if_stall;

  // Misaligned entries are filled at allocation, so every allocated unfilled
  // entry is an aligned request still owed an ack. Responses return in order,
  // hence the oldest such entry (searching from the head) takes the next ack.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    w_unfilled_cnt = '0;
    w_fill_hit     = 1'b0;
    w_fill_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_idx = r_rptr + PTR_W'(i);
      if ((CNT_W'(i) < r_alloc_cnt) && !r_mem[v_idx].filled) begin
        w_unfilled_cnt = w_unfilled_cnt + CNT_W'(1);
        if (!w_fill_hit) begin
          w_fill_hit = 1'b1;
          w_fill_idx = v_idx;
        end
      end
    end
  end

  // An ack arriving in the flush cycle retires one owed response, but only
  // if one is actually owed; a spurious ack must not underflow the count.
  assign w_flush_dec = imem_ack & ((r_drop_cnt != '0) | (w_unfilled_cnt != '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_alloc_cnt <= '0;
      r_drop_cnt  <= '0;
    end else if (if_flush) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i].filled <= 1'b0;
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_alloc_cnt <= '0;
      r_drop_cnt  <= r_drop_cnt + w_unfilled_cnt - CNT_W'(w_flush_dec);
    end else begin
      if (imem_ack) begin
        if (r_drop_cnt != '0) begin
          r_drop_cnt <= r_drop_cnt - CNT_W'(1);
        end else if (w_fill_hit) begin
          r_mem[w_fill_idx].parcel     <= imem_q;
          r_mem[w_fill_idx].page_fault <= imem_err;
          r_mem[w_fill_idx].filled     <= 1'b1;
        end
      end
      if (w_pop) begin
        r_mem[r_rptr].filled <= 1'b0;
        r_rptr               <= r_rptr + PTR_W'(1);
      end
      if (w_push) begin
        r_mem[r_wptr] <= '{pc:         if_nxt_pc,
                           parcel:     '0,
                           filled:     !w_aligned,
                           misaligned: !w_aligned,
                           page_fault: 1'b0};
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      r_alloc_cnt <= r_alloc_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_riscv_imem_prefetch.sv
module tb_riscv_imem_prefetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] if_nxt_pc;
  logic        if_stall_nxt_pc;
  logic        if_stall;
  logic        if_flush;
  logic [31:0] if_parcel;
  logic [31:0] if_parcel_pc;
  logic        if_parcel_valid;
  logic        if_parcel_misaligned;
  logic        if_parcel_page_fault;
  logic        imem_req;
  logic [31:0] imem_adr;
  logic        imem_gnt;
  logic        imem_ack;
  logic [31:0] imem_q;
  logic        imem_err;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_fire = 0;
  logic        mem_hold = 1'b0;
  logic [31:0] pend[$];

  always #5 clk = ~clk;

  riscv_imem_prefetch #(.XLEN(32), .PARCEL_SIZE(32), .DEPTH(4)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .if_nxt_pc            (if_nxt_pc),
    .if_stall_nxt_pc      (if_stall_nxt_pc),
    .if_stall             (if_stall),
    .if_flush             (if_flush),
    .if_parcel            (if_parcel),
    .if_parcel_pc         (if_parcel_pc),
    .if_parcel_valid      (if_parcel_valid),
    .if_parcel_misaligned (if_parcel_misaligned),
    .if_parcel_page_fault (if_parcel_page_fault),
    .imem_req             (imem_req),
    .imem_adr             (imem_adr),
    .imem_gnt             (imem_gnt),
    .imem_ack             (imem_ack),
    .imem_q               (imem_q),
    .imem_err             (imem_err)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h200: return 32'h0000_0013;
      32'h204: return 32'h0010_0093;
      32'h208: return 32'h0020_0113;
      32'h20C: return 32'h0030_0193;
      32'h100, 32'h104: return 32'hDEAD_0000;
      32'h300: return 32'h3000_0013;
      32'h400: return 32'h4000_0013;
      default: return 32'hBAD0_0000 | a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock. Requests granted in the cycle just ending are queued;
  // unless held, the oldest queued request is answered in the new cycle.
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    fire = imem_req && imem_gnt;
    a    = imem_adr;
    @(posedge clk);
    #1;
    if (fire) begin
      pend.push_back(a);
      n_fire++;
    end
    if (!mem_hold && pend.size() > 0) begin
      a        = pend.pop_front();
      imem_ack = 1'b1;
      imem_q   = mem_data(a);
      imem_err = (a == 32'h300);
    end else begin
      imem_ack = 1'b0;
      imem_q   = '0;
      imem_err = 1'b0;
    end
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] q);
    check({tag, "_valid"}, {31'b0, if_parcel_valid}, 32'd1);
    check({tag, "_pc"}, if_parcel_pc, pc);
    check({tag, "_parcel"}, if_parcel, q);
  endtask

  initial begin
    logic seen;
    rstn = 1'b0; if_nxt_pc = 32'h200; if_stall = 1'b0; if_flush = 1'b0;
    imem_gnt = 1'b1; imem_ack = 1'b0; imem_q = '0; imem_err = 1'b0;

    // reset values
    #3;
    check("rst_valid", {31'b0, if_parcel_valid}, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_stall_nxt", {31'b0, if_stall_nxt_pc}, 32'd1);
    check("rst_parcel", if_parcel, 32'h0);
    check("rst_pc", if_parcel_pc, 32'h0);
    check("rst_flags", {30'b0, if_parcel_misaligned, if_parcel_page_fault}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // in-order streaming, 1-cycle memory
    if_nxt_pc = 32'h200; #1;
    check("str_req", {31'b0, imem_req}, 32'd1);
    check("str_accept", {31'b0, if_stall_nxt_pc}, 32'd0);
    tick();
    if_nxt_pc = 32'h204; #1;
    check("str_valid_c1", {31'b0, if_parcel_valid}, 32'd0);
    tick();
    if_nxt_pc = 32'h208; #1;
    expect_head("str0", 32'h200, 32'h0000_0013);
    tick();
    imem_gnt = 1'b0; #1;
    expect_head("str1", 32'h204, 32'h0010_0093);
    tick(); #1;
    expect_head("str2", 32'h208, 32'h0020_0113);
    tick(); #1;
    check("str_empty", {31'b0, if_parcel_valid}, 32'd0);

    // fill to DEPTH while stalled
    if_stall = 1'b1; imem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_nxt_pc = 32'h200 + 32'(4 * i); #1;
      check("full_accept", {31'b0, if_stall_nxt_pc}, 32'd0);
      tick();
    end
    if_nxt_pc = 32'h210; #1;
    check("full_stall_nxt", {31'b0, if_stall_nxt_pc}, 32'd1);
    check("full_no_req", {31'b0, imem_req}, 32'd0);
    tick();
    imem_gnt = 1'b0; #1;
    expect_head("full_hold", 32'h200, 32'h0000_0013);
    tick(); #1;
    expect_head("full_hold2", 32'h200, 32'h0000_0013);
    if_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      expect_head("full_pop", 32'h200 + 32'(4 * i), mem_data(32'h200 + 32'(4 * i)));
      tick();
    end
    #1;
    check("full_drained", {31'b0, if_parcel_valid}, 32'd0);

    // flush with two requests outstanding
    mem_hold = 1'b1; imem_gnt = 1'b1;
    if_nxt_pc = 32'h100; #1; tick();
    if_nxt_pc = 32'h104; #1; tick();
    if_flush = 1'b1; mem_hold = 1'b0; #1;
    check("fl_stall_nxt", {31'b0, if_stall_nxt_pc}, 32'd1);
    check("fl_no_req", {31'b0, imem_req}, 32'd0);
    tick();
    if_flush = 1'b0; if_stall = 1'b1; if_nxt_pc = 32'h400; #1;
    check("fl_accept_400", {31'b0, if_stall_nxt_pc}, 32'd0);
    tick();
    imem_gnt = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      #1;
      if (if_parcel_valid) begin
        seen = 1'b1;
        expect_head("fl_first", 32'h400, 32'h4000_0013);
      end else begin
        tick();
      end
    end
    check("fl_seen", {31'b0, seen}, 32'd1);
    if_stall = 1'b0; tick(); #1;
    check("fl_drained", {31'b0, if_parcel_valid}, 32'd0);

    // misaligned follows an aligned fetch
    n_fire = 0; if_stall = 1'b1; imem_gnt = 1'b1;
    if_nxt_pc = 32'h200; #1;
    check("mis_req_aligned", {31'b0, imem_req}, 32'd1);
    tick();
    if_nxt_pc = 32'h202; #1;
    check("mis_req_none", {31'b0, imem_req}, 32'd0);
    check("mis_accept", {31'b0, if_stall_nxt_pc}, 32'd0);
    tick();
    if_nxt_pc = 32'h210; imem_gnt = 1'b0; #1;
    tick(); #1;
    expect_head("mis0", 32'h200, 32'h0000_0013);
    check("mis0_flag", {31'b0, if_parcel_misaligned}, 32'd0);
    check("mis_fire_cnt", 32'(n_fire), 32'd1);
    if_stall = 1'b0; tick(); #1;
    expect_head("mis1", 32'h202, 32'h0);
    check("mis1_flag", {31'b0, if_parcel_misaligned}, 32'd1);
    tick(); #1;
    check("mis_drained", {31'b0, if_parcel_valid}, 32'd0);

    // error response
    if_stall = 1'b1; imem_gnt = 1'b1; if_nxt_pc = 32'h300; #1;
    tick();
    imem_gnt = 1'b0; #1;
    tick(); #1;
    expect_head("err", 32'h300, 32'h3000_0013);
    check("err_pf", {31'b0, if_parcel_page_fault}, 32'd1);
    if_stall = 1'b0; tick(); #1;
    check("err_drained", {31'b0, if_parcel_valid}, 32'd0);

    // reset mid-stream with three entries held
    if_stall = 1'b1; imem_gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_nxt_pc = 32'h200 + 32'(4 * i); #1; tick();
    end
    imem_gnt = 1'b0; #1; tick(); #1; tick(); #1;
    expect_head("rs_pre", 32'h200, 32'h0000_0013);
    rstn = 1'b0; #1;
    check("rs_valid", {31'b0, if_parcel_valid}, 32'd0);
    check("rs_stall_nxt", {31'b0, if_stall_nxt_pc}, 32'd1);
    check("rs_req", {31'b0, imem_req}, 32'd0);
    pend.delete(); imem_ack = 1'b0; imem_q = '0; imem_err = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1; if_stall = 1'b0; imem_gnt = 1'b1; if_nxt_pc = 32'h200; #1;
    check("rs_post_valid", {31'b0, if_parcel_valid}, 32'd0);
    check("rs_accept", {31'b0, if_stall_nxt_pc}, 32'd0);
    tick();
    imem_gnt = 1'b0; #1;
    tick(); #1;
    expect_head("rs_fetch", 32'h200, 32'h0000_0013);
    check("rs_fetch_flags", {30'b0, if_parcel_misaligned, if_parcel_page_fault}, 32'd0);
    tick(); #1;
    check("rs_drained", {31'b0, if_parcel_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_imem_prefetch.md
RISCV_IMEM_PREFETCH -- requirements
Module: riscv_imem_prefetch

Interface
REQ-001 SHALL have parameter XLEN, default 32: address and PC width.
REQ-002 SHALL have parameter PARCEL_SIZE, default 32: fetched parcel width.
REQ-003 SHALL have parameter DEPTH, default 4: entry count; a power of two, at least 2.
REQ-004 SHALL have a single clock and an asynchronous active-low reset: clk (input, 1, clock); rstn (input, 1, reset).
REQ-005 SHALL have the core-side ports:
- if_nxt_pc (in, XLEN): fetch address offered by the core.
- if_stall_nxt_pc (out, 1): when high, if_nxt_pc is not accepted this cycle.
- if_stall (in, 1): core is not consuming a parcel.
- if_flush (in, 1): discard all fetched and outstanding parcels.
- if_parcel (out, PARCEL_SIZE): head-entry instruction data.
- if_parcel_pc (out, XLEN): address of the head parcel.
- if_parcel_valid (out, 1): head entry is filled.
- if_parcel_misaligned (out, 1): head-entry misaligned flag.
- if_parcel_page_fault (out, 1): head-entry page-fault/error flag.
REQ-006 SHALL have the memory-side ports:
- imem_req (out, 1): request.
- imem_adr (out, XLEN): request address.
- imem_gnt (in, 1): request accepted this cycle.
- imem_ack (in, 1): in-order response.
- imem_q (in, PARCEL_SIZE): response data.
- imem_err (in, 1): response error.

Function
REQ-007 SHALL track alloc_cnt (entries allocated, filled or not) and drop_cnt (stale requests still owed an ack); full = (alloc_cnt + drop_cnt == DEPTH).
REQ-008 SHALL drive if_stall_nxt_pc = full | if_flush | (aligned & !imem_gnt), where aligned = (if_nxt_pc[1:0] == 0).
REQ-009 SHALL drive imem_req = !full & !if_flush & aligned, and imem_adr = if_nxt_pc, both combinationally.
REQ-010 SHALL, when an address is accepted (if_stall_nxt_pc low), allocate the tail entry holding pc=if_nxt_pc with filled=0.
REQ-011 SHALL, for a misaligned accepted address, issue no memory request and write the entry filled=1, misaligned=1, data=0.
REQ-012 SHALL, on imem_ack with drop_cnt == 0, fill the oldest unfilled aligned entry with imem_q and page_fault=imem_err.
REQ-013 SHALL, on imem_ack with drop_cnt > 0, discard the response and decrement drop_cnt.
REQ-014 SHALL drive if_parcel_valid = head.filled & !if_flush; valid is first seen the cycle after the ack (minimum issue-to-valid latency 2 cycles with a 1-cycle memory).
REQ-015 SHALL pop the head when if_parcel_valid & !if_stall; a push and a pop in the same cycle both take effect.
REQ-016 SHALL, on if_flush, empty all entries and set drop_cnt_next = drop_cnt + (aligned outstanding unfilled entries) - (imem_ack ? 1 : 0); no address is accepted in the flush cycle.
REQ-017 SHALL present output parcels strictly in acceptance order, with read/write pointers wrapping modulo DEPTH.
REQ-018 SHALL hold if_parcel, if_parcel_pc and the flags stable while valid and stalled.

Reset
REQ-019 SHALL, with rstn low, asynchronously clear alloc_cnt, drop_cnt, pointers and all filled flags.
REQ-020 SHALL drive if_parcel_valid=0, imem_req=0 and if_stall_nxt_pc=1 while rstn is low.
REQ-021 SHALL drive if_parcel, if_parcel_pc and the flags to 0 out of reset.
REQ-022 SHALL treat a reset asserted mid-operation as abandoning all outstanding acks; the memory is reset together with the block.

Structure
REQ-023 SHALL add no new package types; the entry struct (pc, parcel, filled, misaligned, page_fault) is block-local, and riscv_pkg stays unchanged.
REQ-024 SHALL implement the storage inline with no sub-module; the single register array uses no memory macro.

Verification
REQ-025 SHALL cover in-order streaming: gnt=1, 1-cycle ack, pc 0x200/0x204/0x208, q 0x00000013/0x00100093/0x00200113 -> valid parcels in that order, first valid 2 cycles after issue, then one per cycle.
REQ-026 SHALL cover the full condition: if_stall=1, DEPTH=4, addresses 0x200..0x20C -> if_stall_nxt_pc=1 after the 4th accept with no 5th imem_req; releasing if_stall -> four parcels pop in order.
REQ-027 SHALL cover flush with outstanding requests: 2 requests outstanding, then if_flush -> the next 2 acks (q=0xDEAD0000) are never valid; the first valid parcel afterwards has if_parcel_pc=0x400.
REQ-028 SHALL cover misalignment: accept 0x200, then 0x202 -> one imem_req only; the 0x200 parcel appears first, then pc 0x202 with misaligned=1.
REQ-029 SHALL cover error responses: ack with imem_err=1 for pc 0x300 -> if_parcel_pc=0x300 with if_parcel_page_fault=1.
REQ-030 SHALL cover reset mid-stream: rstn low with 3 entries held -> valid=0 immediately; after release, alloc_cnt=0 and the first accept at 0x200 is fetched normally.
